// File: rtl/imm_gen_stage.sv
// RV32I immediate-generation pipeline stage: opcode classification, immediate
// gather/sign-extension, and a 2-entry skid buffer with valid/ready on both sides.
module imm_gen_stage #(
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_imm,
    output logic [2:0]           out_fmt,
    output logic                 out_illegal,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [1:0]           occupancy
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [31:0]          imm;
        logic [2:0]           fmt;
        logic                 illegal;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t dec_entry;
    entry_t main_entry;
    entry_t skid_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   in_xfer;
    logic   out_xfer;

    // Decode the incoming word so the buffer only ever stores finished results.
    always_comb begin
        dec_entry         = '0;
        dec_entry.tag     = in_tag;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec_entry.fmt = FMT_I;
                dec_entry.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_entry.fmt = FMT_S;
                dec_entry.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_entry.fmt = FMT_B;
                dec_entry.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_entry.fmt = FMT_U;
                dec_entry.imm = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_entry.fmt = FMT_J;
                dec_entry.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_entry.fmt = FMT_R;
            end
            default: begin
                dec_entry.fmt     = FMT_ILL;
                dec_entry.illegal = 1'b1;
            end
        endcase
    end

    // in_ready depends only on registered state, so out_ready never reaches it.
    assign in_ready  = !skid_valid;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;

    // Main register feeds the output; skid catches one entry while downstream stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer || !main_valid) begin
            if (skid_valid) begin
                main_entry <= skid_entry;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_entry <= dec_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_entry <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_entry.imm;
    assign out_fmt     = main_entry.fmt;
    assign out_illegal = main_entry.illegal;
    assign out_tag     = main_entry.tag;
    assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
